framebuffer_scanout: RTL and testbench

- Pixel-fetch and colour stage directly downstream of the 160x120 video timing generator.
- Consumes hpos/vpos/display_on/hsync/vsync and issues reads to a double-buffered 4bpp framebuffer RAM.
- Maps each pixel through a CPU-writable 16-entry palette and drives 12-bit RGB plus sync outputs delayed to stay pixel-aligned.
- Handles the CPU page-swap handshake at frame boundaries.

---
 rtl/framebuffer_scanout.sv | 113 +++++++++++
 tb/tb_framebuffer_scanout.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/framebuffer_scanout.sv
// framebuffer_scanout
//   Pixel-fetch and colour stage behind the 160x120 video timing generator.
//   Turns each (hpos, vpos) into a read of a double-buffered 4bpp framebuffer
//   and maps the returned index through a CPU-writable 16-entry palette.
//   The timing signals are delayed so that they stay aligned with rgb.
//   Page swaps happen only at the first blanking line.
//
// Ports
//   clk, reset           pixel clock, async active-high reset
//   hpos, vpos           position from the timing generator
//   display_on           visible-area flag
//   hsync, vsync         sync inputs
//   fb_addr, fb_rd       framebuffer read address {page, pixel_index} and strobe
//   fb_data              palette index, returned RD_LATENCY cycles after fb_addr
//   pal_we/addr/wdata    palette write port, data is {r,g,b} 4:4:4
//   swap_req, swap_ack   CPU page-swap request (level) and one-cycle ack
//   display_page         page being scanned out
//   rgb                  12-bit pixel colour
//   hsync_out, vsync_out, display_on_out   inputs delayed to align with rgb
module framebuffer_scanout #(
  parameter int unsigned H_DISPLAY  = 160,
  parameter int unsigned V_DISPLAY  = 120,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  hpos,
  input  logic [6:0]  vpos,
  input  logic        display_on,
  input  logic        hsync,
  input  logic        vsync,
  output logic [15:0] fb_addr,
  output logic        fb_rd,
  input  logic [3:0]  fb_data,
  input  logic        pal_we,
  input  logic [3:0]  pal_addr,
  input  logic [11:0] pal_wdata,
  input  logic        swap_req,
  output logic        swap_ack,
  output logic        display_page,
  output logic [11:0] rgb,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        display_on_out
);

  // Input sample to rgb/sync outputs: address stage, RAM latency, colour stage.
  localparam int unsigned L = RD_LATENCY + 2;

  logic [14:0] pixel_index;
  logic        swap_point;
  logic        swap_take;

  logic [L-1:0] hs_sr;
  logic [L-1:0] vs_sr;
  logic [L-1:0] de_sr;

  logic [11:0] palette [16];

  // vpos*160 = vpos*128 + vpos*32, so the common geometry needs no multiplier.
  if (H_DISPLAY == 160) begin : g_pix_shift
    assign pixel_index = ({8'd0, vpos} << 7) + ({8'd0, vpos} << 5) + {7'd0, hpos};
  end else begin : g_pix_mul
    assign pixel_index = ({8'd0, vpos} * 15'(H_DISPLAY)) + {7'd0, hpos};
  end

  assign swap_point = (hpos == '0) && (vpos == 7'(V_DISPLAY));
  assign swap_take  = swap_point && swap_req;

  // Fetch, timing delay line, colour lookup and page control.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fb_addr      <= '0;
      hs_sr        <= '0;
      vs_sr        <= '0;
      de_sr        <= '0;
      rgb          <= '0;
      swap_ack     <= 1'b0;
      display_page <= 1'b0;
    end else begin
      if (display_on) begin
        fb_addr <= {display_page, pixel_index};
      end
      hs_sr <= {hs_sr[L-2:0], hsync};
      vs_sr <= {vs_sr[L-2:0], vsync};
      de_sr <= {de_sr[L-2:0], display_on};
      // fb_data is valid one edge before the outputs, as is de_sr[L-2].
      rgb      <= de_sr[L-2] ? palette[fb_data] : '0;
      swap_ack <= swap_take;
      if (swap_take) begin
        display_page <= ~display_page;
      end
    end
  end

  // The lookup above reads the register value before this edge's write,
  // so a same-cycle write to the looked-up entry shows the old colour.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < 16; i++) begin
        palette[4'(i)] <= {3{4'(i)}};
      end
    end else if (pal_we) begin
      palette[pal_addr] <= pal_wdata;
    end
  end

  assign fb_rd          = de_sr[0];
  assign hsync_out      = hs_sr[L-1];
  assign vsync_out      = vs_sr[L-1];
  assign display_on_out = de_sr[L-1];

endmodule

// File: tb/tb_framebuffer_scanout.sv
// tb_framebuffer_scanout
//   Drives framebuffer_scanout from a small timing-generator model and a
//   framebuffer RAM model, predicts fetch-stage and output-stage results
//   into two queues and compares them as the DUT produces them.
module tb_framebuffer_scanout;

  localparam int H_TOTAL = 170;
  localparam int V_TOTAL = 124;
  localparam int LAT     = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  hpos;
  logic [6:0]  vpos;
  logic        display_on;
  logic        hsync;
  logic        vsync;
  logic [15:0] fb_addr;
  logic        fb_rd;
  logic [3:0]  fb_data;
  logic        pal_we;
  logic [3:0]  pal_addr;
  logic [11:0] pal_wdata;
  logic        swap_req;
  logic        swap_ack;
  logic        display_page;
  logic [11:0] rgb;
  logic        hsync_out;
  logic        vsync_out;
  logic        display_on_out;

  framebuffer_scanout #(
    .H_DISPLAY (160),
    .V_DISPLAY (120),
    .RD_LATENCY(1)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .hpos          (hpos),
    .vpos          (vpos),
    .display_on    (display_on),
    .hsync         (hsync),
    .vsync         (vsync),
    .fb_addr       (fb_addr),
    .fb_rd         (fb_rd),
    .fb_data       (fb_data),
    .pal_we        (pal_we),
    .pal_addr      (pal_addr),
    .pal_wdata     (pal_wdata),
    .swap_req      (swap_req),
    .swap_ack      (swap_ack),
    .display_page  (display_page),
    .rgb           (rgb),
    .hsync_out     (hsync_out),
    .vsync_out     (vsync_out),
    .display_on_out(display_on_out)
  );

  always #5 clk = ~clk;

  // Framebuffer RAM, one cycle latency; page 1 content differs from page 0.
  always @(posedge clk) fb_data <= fb_addr[3:0] ^ {fb_addr[15], 3'b000};

  typedef struct {
    int          due;
    logic [15:0] addr;
    logic        rd;
    logic        ack;
    logic        page;
  } s1_t;

  typedef struct {
    int          due;
    logic [3:0]  idx;
    logic        hs;
    logic        vs;
    logic        de;
  } px_t;

  s1_t q_s1[$];
  px_t q_px[$];

  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  int          gh       = 0;
  int          gv       = 0;
  int          ack_seen = 0;
  logic [11:0] pal_model [16];
  logic        exp_page;
  logic [15:0] exp_addr;
  logic        pend_we;
  logic [3:0]  pend_addr;
  logic [11:0] pend_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) pal_model[i] = {3{4'(i)}};
    exp_page = 1'b0;
    exp_addr = '0;
    pend_we  = 1'b0;
    q_s1.delete();
    q_px.delete();
  endtask

  task automatic set_pos(input int h, input int v);
    gh = h;
    gv = v;
  endtask

  // Drive one pixel, predict its results, advance one clock and score.
  task automatic step();
    logic disp;
    logic swap;
    int   pix;
    s1_t  s;
    px_t  p;
    disp       = (gh < 160) && (gv < 120);
    hpos       = 8'(gh);
    vpos       = 7'(gv);
    display_on = disp;
    hsync      = (gh == 160);
    vsync      = (gv == 120);
    pix        = gv * 160 + gh;
    if (disp) exp_addr = {exp_page, 15'(pix)};
    swap = (gh == 0) && (gv == 120) && swap_req;
    s = '{due: cyc + 1, addr: exp_addr, rd: disp, ack: swap, page: swap ? ~exp_page : exp_page};
    p = '{due: cyc + LAT, idx: exp_addr[3:0] ^ {exp_addr[15], 3'b000},
          hs: (gh == 160), vs: (gv == 120), de: disp};
    q_s1.push_back(s);
    q_px.push_back(p);
    if (swap) exp_page = ~exp_page;
    pend_we   = pal_we;
    pend_addr = pal_addr;
    pend_data = pal_wdata;
    gh++;
    if (gh == H_TOTAL) begin
      gh = 0;
      gv = (gv == V_TOTAL - 1) ? 0 : gv + 1;
    end
    @(posedge clk);
    #1;
    cyc++;
    while (q_s1.size() > 0 && q_s1[0].due == cyc) begin
      s = q_s1.pop_front();
      check("fb_addr", fb_addr, s.addr);
      check("fb_rd", fb_rd, s.rd);
      check("swap_ack", swap_ack, s.ack);
      check("display_page", display_page, s.page);
    end
    while (q_px.size() > 0 && q_px[0].due == cyc) begin
      p = q_px.pop_front();
      check("rgb", rgb, p.de ? pal_model[p.idx] : 12'h000);
      check("hsync_out", hsync_out, p.hs);
      check("vsync_out", vsync_out, p.vs);
      check("display_on_out", display_on_out, p.de);
    end
    // A write sampled on this edge only affects lookups after it.
    if (pend_we) pal_model[pend_addr] = pend_data;
    if (swap_ack) ack_seen++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset      = 1'b1;
    hpos       = '0;
    vpos       = '0;
    display_on = 1'b0;
    hsync      = 1'b0;
    vsync      = 1'b0;
    pal_we     = 1'b0;
    pal_addr   = '0;
    pal_wdata  = '0;
    swap_req   = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_fb_addr", fb_addr, 16'h0000);
    check("rst_fb_rd", fb_rd, 1'b0);
    check("rst_rgb", rgb, 12'h000);
    check("rst_hsync_out", hsync_out, 1'b0);
    check("rst_vsync_out", vsync_out, 1'b0);
    check("rst_display_on_out", display_on_out, 1'b0);
    check("rst_swap_ack", swap_ack, 1'b0);
    check("rst_display_page", display_page, 1'b0);

    // Release with the generator running from the top of the frame.
    reset = 1'b0;
    set_pos(0, 0);
    step();
    step();
    check("de_out_not_yet", display_on_out, 1'b0);
    step();
    check("de_out_rise", display_on_out, 1'b1);
    check("rgb_first_pixel", rgb, 12'h000);
    step();
    check("rgb_second_pixel", rgb, 12'h111);
    repeat (200) step();

    // Address arithmetic and the right-hand edge of the last line.
    set_pos(5, 2);
    step();
    check("addr_v2_h5", fb_addr, 16'd325);
    check("rd_v2_h5", fb_rd, 1'b1);
    set_pos(159, 119);
    step();
    check("addr_last_pixel", fb_addr, 16'd19199);
    step();
    check("rd_h160", fb_rd, 1'b0);
    check("addr_hold_h160", fb_addr, 16'd19199);
    step();
    check("hsync_out_early", hsync_out, 1'b0);
    step();
    check("hsync_out_aligned", hsync_out, 1'b1);
    step();
    check("hsync_out_one_cycle", hsync_out, 1'b0);
    repeat (20) step();

    // Palette write on the same edge as an index-3 lookup.
    set_pos(3, 1);
    step();
    step();
    pal_we    = 1'b1;
    pal_addr  = 4'd3;
    pal_wdata = 12'hF00;
    step();
    pal_we = 1'b0;
    check("pal_same_cycle_old", rgb, 12'h333);
    repeat (16) step();
    check("pal_next_lookup_new", rgb, 12'hF00);

    // Single swap requested mid-frame.
    ack_seen = 0;
    set_pos(0, 118);
    swap_req = 1'b1;
    repeat (2 * H_TOTAL) step();
    check("page_before_swap_point", display_page, 1'b0);
    check("ack_before_swap_point", ack_seen, 0);
    step();
    check("page_after_swap", display_page, 1'b1);
    check("ack_pulse", swap_ack, 1'b1);
    swap_req = 1'b0;
    step();
    check("ack_single_cycle", swap_ack, 1'b0);
    repeat ((V_TOTAL - 120) * H_TOTAL - 2 + 10) step();
    check("next_frame_page_bit", fb_addr[15], 1'b1);
    check("ack_count_single", ack_seen, 1);

    // Request held across two swap points.
    ack_seen = 0;
    swap_req = 1'b1;
    set_pos(0, 119);
    repeat (H_TOTAL + 1) step();
    set_pos(0, 119);
    repeat (H_TOTAL + 1) step();
    swap_req = 1'b0;
    step();
    check("ack_count_double", ack_seen, 2);
    check("page_after_double", display_page, 1'b1);

    // Asynchronous reset mid-line at vpos=50.
    pal_we    = 1'b1;
    pal_addr  = 4'd5;
    pal_wdata = 12'hABC;
    step();
    pal_we = 1'b0;
    set_pos(20, 50);
    repeat (10) step();
    reset = 1'b1;
    #2;
    check("async_rgb", rgb, 12'h000);
    check("async_hsync_out", hsync_out, 1'b0);
    check("async_vsync_out", vsync_out, 1'b0);
    check("async_display_on_out", display_on_out, 1'b0);
    check("async_fb_rd", fb_rd, 1'b0);
    check("async_fb_addr", fb_addr, 16'h0000);
    check("async_swap_ack", swap_ack, 1'b0);
    check("async_display_page", display_page, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    set_pos(5, 50);
    step();
    step();
    step();
    check("grey_ramp_restored", rgb, 12'h555);
    repeat (20) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
